// File: rtl/logic_unit_seq.sv
// logic_unit_seq: registered bitwise gate unit with a built-in self-test sweep.
//
// Computes AND, OR, NAND, NOR, XOR, XNOR, BUF(in1) or INV(in1) on WIDTH-bit
// operands. A one-entry output register sits behind a valid/ready handshake.
// A self-test sweep runs every op and operand combination and compresses the
// results into a MISR signature.
//
// Handshake: a beat moves on any rising edge where valid && ready are both high.
// A producer holds valid and its data stable until that edge. ready may depend
// combinationally on the other side's valid, but valid never depends on ready.
//
// Optional feature: define LOGIC_UNIT_TRISTATE_EN to sample `enable` with each
// operand. With enable=0, out_z registers all ones and out_data registers 0.
// Without the macro, `enable` is ignored and out_z is always 0.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake
//   op, in1, in2        op select (0..7) and operands
//   enable              output enable (tristate build only)
//   out_valid/out_ready result handshake
//   out_data, out_z     registered result and per-bit high-impedance flag
//   sweep_start         request a self-test sweep
//   sweep_busy          sweep in progress
//   sweep_done          one-cycle pulse at the end of a sweep
//   signature           MISR result
//   fsm_state           debug view of the sweep FSM (0 IDLE, 1 SWEEP, 2 DONE)
module logic_unit_seq #(
  parameter int               WIDTH      = 8,
  parameter int               SWEEP_BITS = 4,
  parameter logic [WIDTH-1:0] POLY       = 8'h1D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_z,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [WIDTH-1:0] signature,
  output logic [1:0]       fsm_state
);

  localparam int CW = 3 + 2 * SWEEP_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sig_q, sig_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [WIDTH-1:0]  out_z_q, out_z_d;

  logic [2:0]        sw_op;
  logic [WIDTH-1:0]  sw_in1, sw_in2, sw_res, op_res;
  logic              xfer;

  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0]       f,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (f)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~(a & b);
      3'd3:    r = ~(a | b);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      3'd6:    r = a;
      default: r = ~a;
    endcase
    return r;
  endfunction

  // Sweep operands come straight from the counter fields:
  // {op, in2, in1} with in1 in the low bits, each zero-extended.
  always_comb begin
    sw_op  = cnt_q[CW-1 -: 3];
    sw_in1 = '0;
    sw_in2 = '0;
    sw_in1[SWEEP_BITS-1:0] = cnt_q[SWEEP_BITS-1:0];
    sw_in2[SWEEP_BITS-1:0] = cnt_q[2*SWEEP_BITS-1 -: SWEEP_BITS];
  end

  // The sweep never looks at `enable`; its results are always the enabled value.
  assign sw_res = gate_fn(sw_op, sw_in1, sw_in2);
  assign op_res = gate_fn(op, in1, in2);

  // sweep_start blocks acceptance in the same cycle, so a sweep and a
  // transfer can never begin together.
  assign in_ready = (state_q == IDLE) && !sweep_start && (!out_valid_q || out_ready);
  assign xfer     = in_valid && in_ready;

  // Sweep FSM: next state, counter and signature.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    case (state_q)
      IDLE: begin
        if (sweep_start && !out_valid_q) begin
          state_d = SWEEP;
          cnt_d   = '0;
          sig_d   = '0;
        end
      end
      SWEEP: begin
        sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ sw_res;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {CW{1'b1}}) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register: load on transfer, otherwise drain when downstream takes it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_z_d     = out_z_q;
    if (xfer) begin
      out_valid_d = 1'b1;
`ifdef LOGIC_UNIT_TRISTATE_EN
      out_data_d  = enable ? op_res : '0;
      out_z_d     = enable ? '0 : '1;
`else
      out_data_d  = op_res;
      out_z_d     = '0;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifndef LOGIC_UNIT_TRISTATE_EN
  logic unused_enable;
  assign unused_enable = enable;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sig_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_z_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_z_q     <= out_z_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_z      = out_z_q;
  assign sweep_busy = (state_q == SWEEP);
  assign sweep_done = (state_q == DONE);
  assign signature  = sig_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed testbench for logic_unit_seq (WIDTH=8, SWEEP_BITS=4, POLY=8'h1D).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or #1 after the input change for the combinational in_ready.
module tb_logic_unit_seq;

  localparam int         W     = 8;
  localparam int         SB    = 4;
  localparam int         CW    = 3 + 2 * SB;
  localparam logic [7:0] POLY  = 8'h1D;
  localparam int         NSWP  = 8 * (1 << (2 * SB));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [2:0]   op;
  logic [W-1:0] in1, in2;
  logic         enable;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data, out_z;
  logic         sweep_start, sweep_busy, sweep_done;
  logic [W-1:0] signature;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model_sig;

  logic [W-1:0] exp_q[$];

  logic_unit_seq #(.WIDTH(W), .SWEEP_BITS(SB), .POLY(POLY)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in1(in1), .in2(in2), .enable(enable),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_z(out_z),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .signature(signature), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] gate_model(input logic [2:0] f,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    case (f)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [W-1:0] misr_model();
    logic [W-1:0]  s;
    logic [CW-1:0] k;
    logic [W-1:0]  a, b;
    logic [2:0]    f;
    s = '0;
    for (int i = 0; i < NSWP; i++) begin
      k = CW'(i);
      f = k[CW-1 -: 3];
      a = W'(k[SB-1:0]);
      b = W'(k[2*SB-1 -: SB]);
      s = {s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : 8'h00) ^ gate_model(f, a, b);
    end
    return s;
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; op = '0; in1 = '0; in2 = '0; enable = 1'b1;
    out_ready = 1'b0; sweep_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++; if (out_z !== 8'h00) begin errors++; $display("FAIL reset_out_z got %h want 00", out_z); end
    checks++; if (sweep_busy !== 1'b0 || sweep_done !== 1'b0) begin errors++; $display("FAIL reset_sweep got busy=%b done=%b want 0 0", sweep_busy, sweep_done); end
    checks++; if (signature !== 8'h00) begin errors++; $display("FAIL reset_signature got %h want 00", signature); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", fsm_state); end
  endtask

  // op 0..7 back to back with in1=C5, in2=3A and out_ready held high.
  task automatic test_back_to_back();
    logic [W-1:0] exp_v;
    exp_q = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hC5, 8'h3A};
    out_ready = 1'b1; in1 = 8'hC5; in2 = 8'h3A;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_v) begin
          errors++;
          $display("FAIL b2b_op%0d got valid=%b data=%h want valid=1 data=%h", i - 1, out_valid, out_data, exp_v);
        end
      end
      if (i < 8) begin
        op = 3'(i); in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d got %b want 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0; op = 3'd4; in1 = 8'h0F; in2 = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    op = 3'd0; in1 = 8'hFF; in2 = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hF0) begin errors++; $display("FAIL bp_hold%0d got valid=%b data=%h want valid=1 data=f0", i, out_valid, out_data); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h0F) begin errors++; $display("FAIL bp_next got valid=%b data=%h want valid=1 data=0f", out_valid, out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got valid=%b want 0", out_valid); end
  endtask

  task automatic do_sweep(input int tag);
    int busy_cnt = 0;
    bit finished = 1'b0;
    bit valid_seen = 1'b0;
    @(negedge clk);
    sweep_start = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sweep%0d_start_ready got %b want 0", tag, in_ready); end
    @(negedge clk);
    sweep_start = 1'b0;
    for (int c = 0; c < NSWP + 100 && !finished; c++) begin
      if (sweep_busy === 1'b1) busy_cnt++;
      if (out_valid !== 1'b0) valid_seen = 1'b1;
      if (sweep_done === 1'b1) finished = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!finished) begin errors++; $display("FAIL sweep%0d_done got no pulse want pulse", tag); end
    checks++; if (busy_cnt != NSWP) begin errors++; $display("FAIL sweep%0d_busy_len got %0d want %0d", tag, busy_cnt, NSWP); end
    checks++; if (valid_seen) begin errors++; $display("FAIL sweep%0d_out_valid got 1 want 0", tag); end
    checks++; if (signature !== model_sig) begin errors++; $display("FAIL sweep%0d_sig got %h want %h", tag, signature, model_sig); end
    @(negedge clk);
    checks++; if (sweep_done !== 1'b0 || sweep_busy !== 1'b0) begin errors++; $display("FAIL sweep%0d_end got busy=%b done=%b want 0 0", tag, sweep_busy, sweep_done); end
    repeat (3) @(negedge clk);
    checks++; if (signature !== model_sig) begin errors++; $display("FAIL sweep%0d_sig_hold got %h want %h", tag, signature, model_sig); end
  endtask

  task automatic test_sweep();
    do_sweep(1);
    do_sweep(2);
  endtask

  task automatic test_reset_mid_sweep();
    bit done_seen = 1'b0;
    // Leave a result behind first so reset has something to clear.
    @(negedge clk);
    out_ready = 1'b1; op = 3'd6; in1 = 8'h5A; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (sweep_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b want 1", sweep_busy); end
    rst = 1'b1;
    #1;
    checks++; if (sweep_busy !== 1'b0 || sweep_done !== 1'b0) begin errors++; $display("FAIL rst_mid_sweep got busy=%b done=%b want 0 0", sweep_busy, sweep_done); end
    checks++; if (signature !== 8'h00) begin errors++; $display("FAIL rst_mid_sig got %h want 00", signature); end
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_z !== 8'h00) begin errors++; $display("FAIL rst_mid_out got valid=%b data=%h z=%h want 0 00 00", out_valid, out_data, out_z); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sweep_done !== 1'b0) done_seen = 1'b1;
      if (i == 1) rst = 1'b0;
    end
    checks++; if (done_seen) begin errors++; $display("FAIL rst_mid_done got pulse want none"); end
    do_sweep(3);
  endtask

`ifdef LOGIC_UNIT_TRISTATE_EN
  task automatic test_tristate();
    @(negedge clk);
    out_ready = 1'b1; op = 3'd6; in1 = 8'hA5; in2 = 8'h00; enable = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    checks++; if (out_z !== 8'hFF || out_data !== 8'h00) begin errors++; $display("FAIL tri_off got z=%h data=%h want ff 00", out_z, out_data); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_z !== 8'h00 || out_data !== 8'hA5) begin errors++; $display("FAIL tri_on got z=%h data=%h want 00 a5", out_z, out_data); end
    @(negedge clk);
  endtask
`endif

  initial begin
    model_sig = misr_model();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_sweep();
    test_reset_mid_sweep();
`ifdef LOGIC_UNIT_TRISTATE_EN
    test_tristate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
